// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multicycle MIPS-subset controller.
// MC_CTRL_BNE_EN adds the BNE state and enables the bne opcode.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StAddiEx = 4'd9,
    StAddiWb = 4'd10,
    StJump   = 4'd11
`ifdef MC_CTRL_BNE_EN
    , StBne  = 4'd12
`endif
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that talk to the shared memory and therefore honour wait cycles.
  function automatic logic is_mem_state(state_e s);
    return (s == StFetch) || (s == StMemRd) || (s == StMemWr);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU control decode: alu_op selects ADD, SUB or a funct-driven operation.
module alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] funct_i,
  input  logic [1:0] alu_op_i,
  output logic [2:0] alu_control_o,
  output logic       funct_illegal_o
);

  // Map alu_op/funct to a 3-bit ALU code; unknown funct falls back to ADD.
  always_comb begin
    alu_control_o   = ALU_ADD;
    funct_illegal_o = 1'b0;
    case (alu_op_i)
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct_i)
          FUNCT_ADD: alu_control_o = ALU_ADD;
          FUNCT_SUB: alu_control_o = ALU_SUB;
          FUNCT_AND: alu_control_o = ALU_AND;
          FUNCT_OR:  alu_control_o = ALU_OR;
          FUNCT_SLT: alu_control_o = ALU_SLT;
          default:   funct_illegal_o = 1'b1;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS-subset controller: Moore FSM plus memory wait-state counter.
// Define MC_CTRL_BNE_EN to support the bne opcode.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [2:0] alu_control,
  output logic       illegal,
  output logic [3:0] state_dbg
);

  localparam logic [3:0] WaitLoad = 4'(MEM_WAIT_CYCLES);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic [1:0] alu_op;
  logic       alu_use;
  logic [2:0] dec_control;
  logic       funct_illegal;

  logic pc_write, branch_taken, ir_w, mem_w, reg_w, ill;
  logic last;

  alu_decoder u_alu_decoder (
    .funct_i        (funct),
    .alu_op_i       (alu_op),
    .alu_control_o  (dec_control),
    .funct_illegal_o(funct_illegal)
  );

  // State and wait counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ALU operation class per state; kept apart so the decoder has no loop back.
  always_comb begin
    alu_op  = ALUOP_ADD;
    alu_use = 1'b0;
    unique case (state_q)
      StFetch, StDecode, StMemAdr, StAddiEx: alu_use = 1'b1;
      StExec: begin
        alu_op  = ALUOP_FUNCT;
        alu_use = 1'b1;
      end
`ifdef MC_CTRL_BNE_EN
      StBranch, StBne: begin
`else
      StBranch: begin
`endif
        alu_op  = ALUOP_SUB;
        alu_use = 1'b1;
      end
      default: ;
    endcase
  end

  assign last = (cnt_q == 4'd0);

  // Next state, wait counter and raw (pre-reset-gating) outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_write     = 1'b0;
    branch_taken = 1'b0;
    ir_w         = 1'b0;
    mem_w        = 1'b0;
    reg_w        = 1'b0;
    ill          = 1'b0;
    iord         = 1'b0;
    mem_to_reg   = 1'b0;
    reg_dst      = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = SRCB_REG;
    pc_src       = PCSRC_ALU;

    unique case (state_q)
      StFetch: begin
        alu_src_b = SRCB_FOUR;
        ir_w      = last;
        pc_write  = last;
        state_d   = StDecode;
      end
      StDecode: begin
        alu_src_b = SRCB_IMM_SH2;
        case (op)
          OP_LW, OP_SW: state_d = StMemAdr;
          OP_RTYPE:     state_d = StExec;
          OP_BEQ:       state_d = StBranch;
`ifdef MC_CTRL_BNE_EN
          OP_BNE:       state_d = StBne;
`endif
          OP_ADDI:      state_d = StAddiEx;
          OP_J:         state_d = StJump;
          default: begin
            ill     = 1'b1;
            state_d = StFetch;
          end
        endcase
      end
      StMemAdr: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (op == OP_SW) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        iord    = 1'b1;
        state_d = StMemWb;
      end
      StMemWb: begin
        reg_w      = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = StFetch;
      end
      StMemWr: begin
        iord    = 1'b1;
        mem_w   = last;
        state_d = StFetch;
      end
      StExec: begin
        alu_src_a = 1'b1;
        ill       = funct_illegal;
        // An unsupported funct skips write-back entirely.
        state_d   = funct_illegal ? StFetch : StAluWb;
      end
      StAluWb: begin
        reg_w   = 1'b1;
        reg_dst = 1'b1;
        state_d = StFetch;
      end
      StBranch: begin
        alu_src_a    = 1'b1;
        pc_src       = PCSRC_ALUOUT;
        branch_taken = zero;
        state_d      = StFetch;
      end
`ifdef MC_CTRL_BNE_EN
      StBne: begin
        alu_src_a    = 1'b1;
        pc_src       = PCSRC_ALUOUT;
        branch_taken = ~zero;
        state_d      = StFetch;
      end
`endif
      StAddiEx: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = StAddiWb;
      end
      StAddiWb: begin
        reg_w   = 1'b1;
        state_d = StFetch;
      end
      StJump: begin
        pc_src   = PCSRC_JUMP;
        pc_write = 1'b1;
        state_d  = StFetch;
      end
      default: state_d = StFetch;
    endcase

    // Memory states hold while the counter drains; reload on every entry.
    if (!last) begin
      state_d = state_q;
      cnt_d   = cnt_q - 4'd1;
    end else if (is_mem_state(state_d)) begin
      cnt_d = WaitLoad;
    end
  end

  assign alu_control = alu_use ? dec_control : ALU_AND;
  assign state_dbg   = state_q;

  // Strobes drop asynchronously while reset is held.
  assign pc_en     = rst_n & (pc_write | branch_taken);
  assign ir_write  = rst_n & ir_w;
  assign mem_write = rst_n & mem_w;
  assign reg_write = rst_n & reg_w;
  assign illegal   = rst_n & ill;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: stimulus pushes hand-written expected
// output vectors per cycle, a negedge monitor pops and compares them.
module tb_mc_control_fsm;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_en;
    logic       iord;
    logic       mw;
    logic       irw;
    logic       m2r;
    logic       rdst;
    logic       rw;
    logic       asa;
    logic [1:0] asb;
    logic [1:0] pcs;
    logic [2:0] aluc;
    logic       ill;
  } vec_t;

  typedef struct {
    string name;
    vec_t  v;
  } item_t;

  localparam vec_t E_RST      = '{st: 4'd0, asb: 2'b01, aluc: 3'b010, default: '0};
  localparam vec_t E_FETCH_W  = '{st: 4'd0, asb: 2'b01, aluc: 3'b010, default: '0};
  localparam vec_t E_FETCH    = '{st: 4'd0, pc_en: 1'b1, irw: 1'b1, asb: 2'b01, aluc: 3'b010,
                                  default: '0};
  localparam vec_t E_DECODE   = '{st: 4'd1, asb: 2'b11, aluc: 3'b010, default: '0};
  localparam vec_t E_DEC_ILL  = '{st: 4'd1, asb: 2'b11, aluc: 3'b010, ill: 1'b1, default: '0};
  localparam vec_t E_MEMADR   = '{st: 4'd2, asa: 1'b1, asb: 2'b10, aluc: 3'b010, default: '0};
  localparam vec_t E_MEMRD    = '{st: 4'd3, iord: 1'b1, default: '0};
  localparam vec_t E_MEMWB    = '{st: 4'd4, rw: 1'b1, m2r: 1'b1, default: '0};
  localparam vec_t E_MEMWR    = '{st: 4'd5, iord: 1'b1, mw: 1'b1, default: '0};
  localparam vec_t E_MEMWR_W  = '{st: 4'd5, iord: 1'b1, default: '0};
  localparam vec_t E_EXEC_SLT = '{st: 4'd6, asa: 1'b1, aluc: 3'b111, default: '0};
  localparam vec_t E_EXEC_ILL = '{st: 4'd6, asa: 1'b1, aluc: 3'b010, ill: 1'b1, default: '0};
  localparam vec_t E_ALUWB    = '{st: 4'd7, rw: 1'b1, rdst: 1'b1, default: '0};
  localparam vec_t E_BR_T     = '{st: 4'd8, pc_en: 1'b1, asa: 1'b1, pcs: 2'b01, aluc: 3'b110,
                                  default: '0};
  localparam vec_t E_BR_N     = '{st: 4'd8, asa: 1'b1, pcs: 2'b01, aluc: 3'b110, default: '0};
  localparam vec_t E_ADDIEX   = '{st: 4'd9, asa: 1'b1, asb: 2'b10, aluc: 3'b010, default: '0};
  localparam vec_t E_ADDIWB   = '{st: 4'd10, rw: 1'b1, default: '0};
  localparam vec_t E_JUMP     = '{st: 4'd11, pc_en: 1'b1, pcs: 2'b10, default: '0};
`ifdef MC_CTRL_BNE_EN
  localparam vec_t E_BNE_T    = '{st: 4'd12, pc_en: 1'b1, asa: 1'b1, pcs: 2'b01, aluc: 3'b110,
                                  default: '0};
`endif

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101, ADDI = 6'b001000, J = 6'b000010, BAD = 6'b111111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op, funct;
  logic       zero;
  logic       sel3;

  logic       pc_en0, iord0, mw0, irw0, m2r0, rdst0, rw0, asa0, ill0;
  logic [1:0] asb0, pcs0;
  logic [2:0] aluc0;
  logic [3:0] st0;
  logic       pc_en3, iord3, mw3, irw3, m2r3, rdst3, rw3, asa3, ill3;
  logic [1:0] asb3, pcs3;
  logic [2:0] aluc3;
  logic [3:0] st3;

  item_t q[$];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  mc_control_fsm #(.MEM_WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
    .pc_en(pc_en0), .iord(iord0), .mem_write(mw0), .ir_write(irw0), .mem_to_reg(m2r0),
    .reg_dst(rdst0), .reg_write(rw0), .alu_src_a(asa0), .alu_src_b(asb0), .pc_src(pcs0),
    .alu_control(aluc0), .illegal(ill0), .state_dbg(st0)
  );

  mc_control_fsm #(.MEM_WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
    .pc_en(pc_en3), .iord(iord3), .mem_write(mw3), .ir_write(irw3), .mem_to_reg(m2r3),
    .reg_dst(rdst3), .reg_write(rw3), .alu_src_a(asa3), .alu_src_b(asb3), .pc_src(pcs3),
    .alu_control(aluc3), .illegal(ill3), .state_dbg(st3)
  );

  vec_t act0, act3, act;
  always_comb begin
    act0 = '{st: st0, pc_en: pc_en0, iord: iord0, mw: mw0, irw: irw0, m2r: m2r0, rdst: rdst0,
             rw: rw0, asa: asa0, asb: asb0, pcs: pcs0, aluc: aluc0, ill: ill0};
    act3 = '{st: st3, pc_en: pc_en3, iord: iord3, mw: mw3, irw: irw3, m2r: m2r3, rdst: rdst3,
             rw: rw3, asa: asa3, asb: asb3, pcs: pcs3, aluc: aluc3, ill: ill3};
    act  = sel3 ? act3 : act0;
  end

  // Monitor: one expected vector per checked cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      item_t it;
      it = q.pop_front();
      checks++;
      if (act !== it.v) begin
        errors++;
        $display("FAIL %s: got %h (state %0d) want %h (state %0d)",
                 it.name, act, act.st, it.v, it.v.st);
      end
    end
  end

  task automatic cyc(input logic [5:0] o, input logic [5:0] f, input logic z, input vec_t e,
                     input string n);
    item_t it;
    op = o;
    funct = f;
    zero = z;
    it.name = n;
    it.v = e;
    q.push_back(it);
    @(posedge clk);
    #1;
  endtask

  initial begin
    item_t it;
    rst_n = 1'b0;
    op = RT;
    funct = 6'b0;
    zero = 1'b0;
    sel3 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cyc(LW, 6'd0, 1'b0, E_RST, "reset_hold");
    rst_n = 1'b1;

    // lw
    cyc(LW, 6'd0, 1'b0, E_FETCH, "lw_fetch");
    cyc(LW, 6'd0, 1'b0, E_DECODE, "lw_decode");
    cyc(LW, 6'd0, 1'b0, E_MEMADR, "lw_memadr");
    cyc(LW, 6'd0, 1'b0, E_MEMRD, "lw_memrd");
    cyc(LW, 6'd0, 1'b0, E_MEMWB, "lw_memwb");
    // R-type slt, then illegal funct
    cyc(RT, 6'b101010, 1'b0, E_FETCH, "slt_fetch");
    cyc(RT, 6'b101010, 1'b0, E_DECODE, "slt_decode");
    cyc(RT, 6'b101010, 1'b0, E_EXEC_SLT, "slt_exec");
    cyc(RT, 6'b101010, 1'b0, E_ALUWB, "slt_aluwb");
    cyc(RT, 6'b000111, 1'b0, E_FETCH, "badf_fetch");
    cyc(RT, 6'b000111, 1'b0, E_DECODE, "badf_decode");
    cyc(RT, 6'b000111, 1'b0, E_EXEC_ILL, "badf_exec");
    // beq taken / not taken
    cyc(BEQ, 6'd0, 1'b1, E_FETCH, "beq1_fetch");
    cyc(BEQ, 6'd0, 1'b1, E_DECODE, "beq1_decode");
    cyc(BEQ, 6'd0, 1'b1, E_BR_T, "beq1_branch");
    cyc(BEQ, 6'd0, 1'b0, E_FETCH, "beq0_fetch");
    cyc(BEQ, 6'd0, 1'b0, E_DECODE, "beq0_decode");
    cyc(BEQ, 6'd0, 1'b0, E_BR_N, "beq0_branch");
    // addi
    cyc(ADDI, 6'd0, 1'b0, E_FETCH, "addi_fetch");
    cyc(ADDI, 6'd0, 1'b0, E_DECODE, "addi_decode");
    cyc(ADDI, 6'd0, 1'b0, E_ADDIEX, "addi_ex");
    cyc(ADDI, 6'd0, 1'b0, E_ADDIWB, "addi_wb");
    // j
    cyc(J, 6'd0, 1'b0, E_FETCH, "j_fetch");
    cyc(J, 6'd0, 1'b0, E_DECODE, "j_decode");
    cyc(J, 6'd0, 1'b0, E_JUMP, "j_jump");
    // sw
    cyc(SW, 6'd0, 1'b0, E_FETCH, "sw_fetch");
    cyc(SW, 6'd0, 1'b0, E_DECODE, "sw_decode");
    cyc(SW, 6'd0, 1'b0, E_MEMADR, "sw_memadr");
    cyc(SW, 6'd0, 1'b0, E_MEMWR, "sw_memwr");
    // bne with zero = 0
    cyc(BNE, 6'd0, 1'b0, E_FETCH, "bne_fetch");
`ifdef MC_CTRL_BNE_EN
    cyc(BNE, 6'd0, 1'b0, E_DECODE, "bne_decode");
    cyc(BNE, 6'd0, 1'b0, E_BNE_T, "bne_state");
`else
    cyc(BNE, 6'd0, 1'b0, E_DEC_ILL, "bne_illegal");
`endif
    // illegal opcode
    cyc(BAD, 6'd0, 1'b0, E_FETCH, "badop_fetch");
    cyc(BAD, 6'd0, 1'b0, E_DEC_ILL, "badop_decode");
    // reset asserted mid-EXEC, sampled before the next clock edge
    cyc(RT, 6'b100000, 1'b0, E_FETCH, "rst_fetch");
    cyc(RT, 6'b100000, 1'b0, E_DECODE, "rst_decode");
    #1;
    rst_n = 1'b0;
    it.name = "rst_async";
    it.v = E_RST;
    q.push_back(it);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(RT, 6'b100000, 1'b0, E_FETCH, "rst_release");
    cyc(RT, 6'b100000, 1'b0, E_DECODE, "rst_decode2");

    // sw with three wait cycles on the second instance
    rst_n = 1'b0;
    sel3 = 1'b1;
    cyc(SW, 6'd0, 1'b0, E_RST, "w3_reset");
    rst_n = 1'b1;
    cyc(SW, 6'd0, 1'b0, E_FETCH, "w3_fetch0");
    cyc(SW, 6'd0, 1'b0, E_DECODE, "w3_decode");
    cyc(SW, 6'd0, 1'b0, E_MEMADR, "w3_memadr");
    for (int i = 0; i < 3; i++) cyc(SW, 6'd0, 1'b0, E_MEMWR_W, "w3_memwr_hold");
    cyc(SW, 6'd0, 1'b0, E_MEMWR, "w3_memwr_last");
    for (int i = 0; i < 3; i++) cyc(SW, 6'd0, 1'b0, E_FETCH_W, "w3_fetch_hold");
    cyc(SW, 6'd0, 1'b0, E_FETCH, "w3_fetch_last");
    cyc(SW, 6'd0, 1'b0, E_DECODE, "w3_decode2");

    repeat (2) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multicycle MIPS-subset controller; sits directly upstream of the ALU.
- Drives its 3-bit ALU control code, selects its operand sources, and consumes its zero flag for branch resolution.
- Also drives PC, IR, memory and register-file strobes for the shared-memory multicycle datapath.
- Moore FSM plus a memory wait-state counter.

Parameters:
- MEM_WAIT_CYCLES, 0, extra stall cycles held in each memory-access state (FETCH, MEMRD, MEMWR); legal range 0..15.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- op  in  6  instr[31:26] from IR
- funct  in  6  instr[5:0] from IR
- zero  in  1  ALU zero flag
- pc_en  out  1  PC load = pc_write | (branch_taken)
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_write  out  1  data memory write strobe
- ir_write  out  1  IR load
- mem_to_reg  out  1  register write-back source: 1 = MDR, 0 = ALUOut
- reg_dst  out  1  destination register: 1 = rd, 0 = rt
- reg_write  out  1  register-file write strobe
- alu_src_a  out  1  ALU A source: 0 = PC, 1 = register A
- alu_src_b  out  2  ALU B source: 00 = B, 01 = const 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- pc_src  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- alu_control  out  3  ALU operation code
- illegal  out  1  one-cycle pulse on an unsupported op/funct
- state_dbg  out  4  current state encoding

Behaviour:
- ALU codes: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT. No other values are ever driven.
- Clock and reset: single clock clk; reset rst_n asynchronous, active-low.
- Reset: state = FETCH, wait counter = 0.
- While rst_n = 0, all strobes are forced to 0: pc_en, mem_write, ir_write, reg_write, illegal.
- Non-strobe outputs show FETCH values: iord 0, alu_src_a 0, alu_src_b 01, alu_control 010, pc_src 00.
- Outputs are a combinational function of state (plus zero for the branch term, and counter == 0 for the memory states).
- States and actions (unlisted outputs are 0):
  - FETCH: ALU computes PC + 4; ir_write and pc_write on the final wait cycle.
  - DECODE: ALU computes PC + (imm << 2) (alu_src_b 11, ADD).
  - MEMADR: A + imm, ADD.
  - MEMRD: iord = 1.
  - MEMWB: reg_write, mem_to_reg.
  - MEMWR: iord = 1; mem_write on the final wait cycle only.
  - EXEC: A op B; alu_control from funct.
  - ALUWB: reg_write, reg_dst.
  - BRANCH: A − B (SUB), pc_src 01; pc_en = zero.
  - ADDIEX: A + imm.
  - ADDIWB: reg_write, reg_dst = 0.
  - JUMP: pc_src 10, pc_en = 1.
- Transitions:
  - FETCH → DECODE.
  - DECODE by op:
    - 100011 (lw) or 101011 (sw) → MEMADR
    - 000000 → EXEC
    - 000100 → BRANCH
    - 001000 → ADDIEX
    - 000010 → JUMP
    - anything else → FETCH with illegal = 1 in DECODE
  - MEMADR → MEMRD (lw) or MEMWR (sw).
  - MEMRD → MEMWB.
  - EXEC → ALUWB.
  - ADDIEX → ADDIWB.
  - MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH, JUMP → FETCH.
- funct map: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT.
  - Any other funct: alu_control 010, illegal pulse in EXEC, next state FETCH.
  - No write-back occurs for an illegal funct.
- Wait states: on entering FETCH, MEMRD or MEMWR, counter loads MEM_WAIT_CYCLES.
  - Each cycle the state is held while counter ≠ 0; counter decrements.
  - The state advances when counter = 0. Strobes fire only in that final cycle.
  - MEM_WAIT_CYCLES = 0 gives exactly one cycle per state.
- Latency at MEM_WAIT_CYCLES = 0:
  - lw 5 cycles; sw 4; R-type 4; addi 4; beq 3; j 3; illegal op 2.
- Branch: zero is sampled in the BRANCH cycle, same cycle as the ALU result. No registering.
- Reset mid-instruction: immediate return to FETCH; in-flight strobes drop asynchronously.

Optional Feature:
- Macro: MC_CTRL_BNE_EN.
- Defined: op 000101 (bne) decodes to state BNE. BNE is identical to BRANCH except pc_en = ~zero. bne latency is 3 cycles.
- Undefined: op 000101 is illegal (pulse in DECODE, return to FETCH). The BNE state does not exist.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state enum (4-bit)
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J
  - funct constants
  - ALU code constants: ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT
  - alu_src_b and pc_src select constants
- Sub-module alu_decoder: combinational funct + alu_op[1:0] → alu_control, funct_illegal.
  - alu_op encoding: 00 ADD, 01 SUB, 10 use funct.

Test Plan:
- Reset: rst_n = 0 mid-EXEC → state_dbg = FETCH immediately, reg_write = 0. Release → ir_write = 1, pc_en = 1 on first edge.
- lw (op 100011), wait = 0 → states FETCH, DECODE, MEMADR, MEMRD, MEMWB over 5 cycles. iord = 1 only in MEMRD; reg_write + mem_to_reg only in MEMWB.
- R-type funct 101010 → alu_control = 111 in EXEC; reg_write = 1, reg_dst = 1 in ALUWB. funct 000111 → illegal pulse and no reg_write.
- beq with zero = 1 → pc_en = 1, pc_src = 01, alu_control = 110 in BRANCH. With zero = 0 → pc_en = 0; FETCH follows either way.
- sw with MEM_WAIT_CYCLES = 3 → MEMWR held 4 cycles, mem_write high only in the 4th. FETCH holds 4 cycles with ir_write only on the last.
- op 000101: without MC_CTRL_BNE_EN → illegal pulse in DECODE. With it, zero = 0 → pc_en = 1.
